// File: rtl/dump_reader.sv
// Capture-RAM readout engine: streams all 2**ADDR_W samples oldest-first over a valid/ack link.
// Define DUMP_CHKSUM_EN to append a modulo-2**DATA_W checksum byte after the samples.
module dump_reader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_dump,
    input  logic              capture_done,
    input  logic [ADDR_W-1:0] trace_end,
    input  logic [DATA_W-1:0] rdata,
    output logic              en,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              send_dump,
    input  logic              dump_ack,
    output logic              dump_finished,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

`ifdef DUMP_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, RD, LATCH, SEND, CHK, FIN} state_t;
    logic [DATA_W-1:0] sum;
`else
    typedef enum logic [2:0] {IDLE, RD, LATCH, SEND, FIN} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;

    assign we   = 1'b0;
    assign addr = rd_ptr;

    // Outputs are registered alongside the state: each branch sets the value
    // the output must carry while the FSM sits in the state being entered.
    // NOTE: every register here uses <= so all branches see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            cnt           <= '0;
            en            <= 1'b0;
            dump_data     <= '0;
            send_dump     <= 1'b0;
            dump_finished <= 1'b0;
            busy          <= 1'b0;
`ifdef DUMP_CHKSUM_EN
            sum           <= '0;
`endif
        end else begin
            en            <= 1'b0;
            send_dump     <= 1'b0;
            dump_finished <= 1'b0;

            // Losing the capture aborts silently: no finish pulse.
            if (state != IDLE && !capture_done) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_dump && capture_done) begin
                            rd_ptr <= trace_end;
                            cnt    <= '0;
`ifdef DUMP_CHKSUM_EN
                            sum    <= '0;
`endif
                            state  <= RD;
                            en     <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                    RD: begin
                        state <= LATCH;
                    end
                    LATCH: begin
                        dump_data <= rdata;
                        send_dump <= 1'b1;
                        state     <= SEND;
                    end
                    SEND: begin
                        if (dump_ack) begin
                            rd_ptr <= rd_ptr + ADDR_W'(1);
                            cnt    <= cnt + (ADDR_W + 1)'(1);
`ifdef DUMP_CHKSUM_EN
                            sum    <= sum + dump_data;
`endif
                            if (cnt == LAST_CNT) begin
`ifdef DUMP_CHKSUM_EN
                                dump_data <= sum + dump_data;
                                send_dump <= 1'b1;
                                state     <= CHK;
`else
                                dump_finished <= 1'b1;
                                state         <= FIN;
`endif
                            end else begin
                                en    <= 1'b1;
                                state <= RD;
                            end
                        end else begin
                            send_dump <= 1'b1;
                        end
                    end
`ifdef DUMP_CHKSUM_EN
                    CHK: begin
                        if (dump_ack) begin
                            dump_finished <= 1'b1;
                            state         <= FIN;
                        end else begin
                            send_dump <= 1'b1;
                        end
                    end
`endif
                    FIN: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dump_reader.sv
// Self-checking bench for dump_reader: table of dump scenarios plus reset/gating sequences,
// compared against a queue-based model of the expected oldest-first sample stream.
module tb_dump_reader;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_dump;
    logic              capture_done;
    logic [ADDR_W-1:0] trace_end;
    logic [DATA_W-1:0] rdata;
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dump_data;
    logic              send_dump;
    logic              dump_ack;
    logic              dump_finished;
    logic              busy;

    logic [DATA_W-1:0] mem [DEPTH];

    int vectors    = 0;
    int miscompares = 0;

    dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_dump    (start_dump),
        .capture_done  (capture_done),
        .trace_end     (trace_end),
        .rdata         (rdata),
        .en            (en),
        .we            (we),
        .addr          (addr),
        .dump_data     (dump_data),
        .send_dump     (send_dump),
        .dump_ack      (dump_ack),
        .dump_finished (dump_finished),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model
    always @(posedge clk) if (en) rdata <= mem[addr];

    typedef struct {
        int         te;       // -1: random trace_end
        int         pat;      // 0: mem[i]=i, 1: random, 2: all 0x01
        int         mode;     // ack policy: 0 always, 1 random, 2 hold 20 cycles at 5th sample
        bit         glitch;   // pulse start_dump mid-dump
        int         abort_at; // drop capture_done after this many transfers, -1 none
        logic [7:0] first;
        logic [7:0] last;
        int         k;
        logic [7:0] exp_k;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_dump(input vec_t v);
        logic [7:0] exp_q[$];
        logic [7:0] s;
        logic [7:0] held;
        int te, c, xfers, fin, fin_c, last_c, first_c, hold, drop_c;
        bit dropped, done;

        te = (v.te < 0) ? int'($urandom_range(0, DEPTH - 1)) : v.te;
        for (int i = 0; i < DEPTH; i++)
            mem[i] = (v.pat == 0) ? 8'(i) : (v.pat == 1) ? 8'($urandom) : 8'h01;

        s = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(mem[(te + i) % DEPTH]);
            s = s + mem[(te + i) % DEPTH];
        end
`ifdef DUMP_CHKSUM_EN
        exp_q.push_back(s);
`endif

        xfers = 0; fin = 0; fin_c = -1; last_c = -1; first_c = -1; hold = 0;
        drop_c = -1; dropped = 0; done = 0; held = '0;
        trace_end    = ADDR_W'(te);
        capture_done = 1'b1;
        dump_ack     = 1'b0;
        @(posedge clk); #1 start_dump = 1'b1;
        @(posedge clk); #1 start_dump = 1'b0;
        trace_end = ADDR_W'($urandom);
        c = 1;
        dump_ack = (v.mode == 1) ? ($urandom_range(0, 3) != 0) : (v.mode != 2 || xfers != 4);

        while (!done) begin
            @(negedge clk);
            if (c == 1) begin
                check("en_after_start", en, 1);
                check("first_addr", addr, te);
            end
            if (send_dump && first_c < 0) first_c = c;
            if (v.mode == 2 && xfers == 4 && send_dump && !dump_ack) begin
                if (hold == 0) held = dump_data;
                else begin
                    check("hold_data", dump_data, held);
                    check("hold_send", send_dump, 1);
                end
                check("hold_en", en, 0);
                hold++;
            end
            if (send_dump && dump_ack) begin
                if (xfers < exp_q.size()) check("sample", dump_data, exp_q[xfers]);
                else check("extra_transfer", xfers, exp_q.size() - 1);
                if (v.pat == 0) begin
                    if (xfers == 0)         check("tab_first", dump_data, v.first);
                    if (xfers == DEPTH - 1) check("tab_last", dump_data, v.last);
                    if (xfers == v.k)       check("tab_kth", dump_data, v.exp_k);
                end
                xfers++;
                last_c = c;
            end
            if (dump_finished) begin
                fin++;
                fin_c = c;
            end
            if (dropped && c == drop_c + 1) begin
                check("abort_busy", busy, 0);
                check("abort_send", send_dump, 0);
                check("abort_en", en, 0);
            end
            if (fin > 0 && c >= fin_c + 3) done = 1;
            if (dropped && c >= drop_c + 10) done = 1;
            if (c > 20000) begin
                check("dump_timeout", c, 0);
                done = 1;
            end
            @(posedge clk); #1;
            c++;
            start_dump = v.glitch && (c == 50);
            if (v.abort_at >= 0 && !dropped && xfers == v.abort_at) begin
                capture_done = 1'b0;
                dropped = 1;
                drop_c = c;
            end
            case (v.mode)
                1:       dump_ack = ($urandom_range(0, 3) != 0);
                2:       dump_ack = !(xfers == 4 && hold < 20);
                default: dump_ack = 1'b1;
            endcase
        end

        check("first_send_latency", first_c, 3);
        if (v.abort_at >= 0) begin
            check("abort_xfers", xfers, v.abort_at);
            check("abort_no_finish", fin, 0);
        end else begin
            check("xfer_count", xfers, exp_q.size());
            check("finish_pulses", fin, 1);
            check("finish_timing", fin_c, last_c + 1);
        end
        if (v.mode == 2) check("hold_cycles", hold, 20);
        check("busy_after", busy, 0);
        start_dump   = 1'b0;
        dump_ack     = 1'b0;
        capture_done = 1'b1;
    endtask

    vec_t vecs[8];
    vec_t rv;

    initial begin
        vecs[0] = '{0,   0, 0, 1'b0, -1,  8'h00, 8'hFF, 256, 8'h00};
        vecs[1] = '{500, 0, 0, 1'b0, -1,  8'hF4, 8'hF3, 12,  8'h00};
        vecs[2] = '{511, 0, 1, 1'b0, -1,  8'hFF, 8'hFE, 1,   8'h00};
        vecs[3] = '{-1,  1, 1, 1'b0, -1,  8'h00, 8'h00, 0,   8'h00};
        vecs[4] = '{0,   2, 0, 1'b0, -1,  8'h00, 8'h00, 0,   8'h00};
        vecs[5] = '{100, 0, 2, 1'b0, -1,  8'h64, 8'h63, 4,   8'h68};
        vecs[6] = '{7,   0, 0, 1'b1, -1,  8'h07, 8'h06, 249, 8'h00};
        vecs[7] = '{300, 1, 0, 1'b0, 100, 8'h00, 8'h00, 0,   8'h00};

        rst_n = 1'b0; start_dump = 1'b0; capture_done = 1'b0;
        trace_end = '0; dump_ack = 1'b0;
        #1;
        check("rst_en", en, 0);
        check("rst_we", we, 0);
        check("rst_addr", addr, 0);
        check("rst_data", dump_data, 0);
        check("rst_send", send_dump, 0);
        check("rst_fin", dump_finished, 0);
        check("rst_busy", busy, 0);
        #22 rst_n = 1'b1;

        // Gating: start without a completed capture must be ignored.
        @(posedge clk); #1 start_dump = 1'b1;
        @(posedge clk); #1 start_dump = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("gate_en", en, 0);
            check("gate_busy", busy, 0);
        end

        foreach (vecs[i]) run_dump(vecs[i]);

        // Asynchronous reset during SEND, then a clean restart from trace_end.
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        trace_end = 9'd37; capture_done = 1'b1; dump_ack = 1'b0;
        @(posedge clk); #1 start_dump = 1'b1;
        @(posedge clk); #1 start_dump = 1'b0;
        begin
            int w;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!send_dump && w < 20);
            check("pre_reset_send", send_dump, 1);
        end
        #1 rst_n = 1'b0;
        #1;
        check("midrst_send", send_dump, 0);
        check("midrst_busy", busy, 0);
        check("midrst_addr", addr, 0);
        check("midrst_en", en, 0);
        check("midrst_data", dump_data, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        rv = '{37, 0, 0, 1'b0, -1, 8'h25, 8'h24, 3, 8'h28};
        run_dump(rv);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dump_reader.md
Name: dump_reader

Overview:
- Readout engine for the capture RAM.
- After a capture completes (capture_done=1) and a dump is requested (start_dump), it reads all 2**ADDR_W samples from the circular trace RAM, oldest first: starting at trace_end, wrapping, ending at trace_end-1.
- Each sample is presented to the downstream serial transmitter with a valid/ack handshake.
- dump_finished signals completion so control logic can clear capture_done and re-arm capture.

Parameters:
- ADDR_W, 9: RAM address width; DEPTH = 2**ADDR_W samples per dump.
- DATA_W, 8: sample width.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- start_dump, input, 1: request a dump; honoured only when idle and capture_done=1.
- capture_done, input, 1: capture buffer holds a complete trace.
- trace_end, input, ADDR_W: address one past the last written sample (oldest sample location).
- rdata, input, DATA_W: RAM read data; synchronous read, valid the cycle after en/addr.
- en, output, 1: RAM enable (read).
- we, output, 1: RAM write enable; tied 0.
- addr, output, ADDR_W: RAM read address.
- dump_data, output, DATA_W: sample being offered.
- send_dump, output, 1: dump_data valid.
- dump_ack, input, 1: transmitter accepts dump_data; a transfer occurs when send_dump && dump_ack.
- dump_finished, output, 1: one-cycle pulse after the final transfer.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset values: state=IDLE; en=0, we=0, addr=0, dump_data=0, send_dump=0, dump_finished=0, busy=0; internal rd_ptr=0, cnt=0.
- IDLE:
  - start_dump && capture_done → rd_ptr<=trace_end, cnt<=0, go to RD.
  - Otherwise stay in IDLE; start_dump is ignored.
- RD: en=1, addr=rd_ptr (combinational from rd_ptr); go to LATCH.
- LATCH: dump_data<=rdata at the end of the cycle; go to SEND.
- SEND:
  - send_dump=1; dump_data is held stable until accepted.
  - On dump_ack: rd_ptr<=rd_ptr+1 (mod DEPTH, natural ADDR_W wrap); cnt<=cnt+1.
  - If cnt==DEPTH-1 at acceptance, go to FIN; otherwise go to RD.
  - Without dump_ack: stay in SEND.
- FIN: dump_finished=1 for exactly one cycle; go to IDLE.
- Latency:
  - start_dump sampled at edge N → en high in cycle N+1 → send_dump high from cycle N+3.
  - Each later sample: send_dump rises 3 cycles after the previous acceptance.
- cnt is ADDR_W+1 bits wide, so DEPTH is representable; exactly DEPTH transfers per dump.
- trace_end is sampled only in IDLE on a start; later changes are ignored for the rest of the dump.
- Abort: capture_done falling in any state other than IDLE forces IDLE next cycle. send_dump drops, en drops, and no dump_finished pulse is produced.
- dump_ack while send_dump=0: ignored.
- start_dump while busy: ignored; it is neither queued nor restarts the dump.
- Asynchronous reset mid-dump: all outputs return to their reset values immediately.
- trace_end=DEPTH-1: first read at DEPTH-1, then wraps to 0 … DEPTH-2.

Optional Feature:
- Macro: DUMP_CHKSUM_EN.
- Defined:
  - An accumulator sum (DATA_W bits, cleared on start) adds each accepted sample modulo 2**DATA_W.
  - After the DEPTH-th transfer, the FSM enters CHK instead of FIN. CHK drives dump_data=sum and send_dump=1 until dump_ack, then goes to FIN.
  - Total transfers = DEPTH+1.
- Undefined: no accumulator, no CHK state; exactly DEPTH transfers.

Test Plan:
- Reset mid-dump: assert rst_n=0 during SEND → send_dump=0, busy=0, addr=0 the same cycle; deassert, then start_dump → dump restarts from trace_end.
- Basic dump:
  - Setup: RAM[i]=i[7:0], trace_end=0, capture_done=1, dump_ack tied 1, pulse start_dump.
  - Expect: 512 transfers of 0x00,0x01,…,0xFF,0x00,…,0xFF.
  - Expect: first send_dump 3 cycles after start, dump_finished pulse once, busy low afterwards.
- Wrap order: trace_end=500, RAM[i]=i[7:0] → first data 0xF4 (addr 500), 12th data 0xFF (addr 511), 13th 0x00 (addr 0), last 0xF3 (addr 499).
- Backpressure: hold dump_ack=0 for 20 cycles during the 5th SEND → dump_data and send_dump stable for all 20 cycles, en=0 throughout, no skipped or duplicated sample once ack resumes.
- Gating and abort:
  - start_dump with capture_done=0 → no en, busy stays 0.
  - During a dump, drop capture_done at transfer 100 → IDLE next cycle, no dump_finished.
  - start_dump pulsed while busy → no effect on the sequence.
- With DUMP_CHKSUM_EN: RAM all 0x01, trace_end=0 → 512 bytes of 0x01, then a 513th byte 0x00 (512 mod 256), then dump_finished.
